// File: rtl/bpred_pkg.sv
// rtl/bpred_pkg.sv - shared types and counter helpers for the 2-bit branch predictor
package bpred_pkg;

  localparam int MAX_TAG_W = 30;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_t;

  // The tag is sized for the smallest legal index; narrower tags are zero-extended.
  typedef struct packed {
    logic                 valid;
    logic [MAX_TAG_W-1:0] tag;
    logic [31:0]          target;
    logic                 jump;
    ctr_t                 ctr;
  } btb_entry_t;

  function automatic ctr_t sat_inc(input ctr_t c);
    return (c == STRONG_T) ? STRONG_T : ctr_t'(c + 2'd1);
  endfunction

  function automatic ctr_t sat_dec(input ctr_t c);
    return (c == STRONG_NT) ? STRONG_NT : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/bpred_ctr_next.sv
// rtl/bpred_ctr_next.sv - next direction-counter value for a resolving branch or jump
module bpred_ctr_next
  import bpred_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  input  logic alloc,
  input  logic is_jump,
  output ctr_t nxt
);

  // A fresh branch starts weakly taken so one not-taken outcome flips it.
  always_comb begin
    nxt = ctr;
    if (alloc)
      nxt = is_jump ? STRONG_T : WEAK_T;
    else if (taken)
      nxt = sat_inc(ctr);
    else
      nxt = sat_dec(ctr);
  end

endmodule

// File: rtl/bpred_2bit.sv
// rtl/bpred_2bit.sv - direct-mapped BTB with 2-bit direction counters and perf counters
module bpred_2bit
  import bpred_pkg::*;
#(
  parameter int INDEX_W = 8,
  parameter int TAG_W   = 30 - INDEX_W
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_pc,
  output logic        o_hit,
  output logic        o_pred_taken,
  output logic [31:0] o_target,
  output logic [31:0] o_pred_pc,
  input  logic        i_update_en,
  input  logic        i_is_jump,
  input  logic [31:0] i_pc_update,
  input  logic        i_taken,
  input  logic [31:0] i_target_update,
  input  logic        i_mispred,
  output logic [31:0] o_br_cnt,
  output logic [31:0] o_mispred_cnt
);

  localparam int DEPTH = 1 << INDEX_W;

  logic [TAG_W-1:0] tag_mem    [DEPTH];
  logic [31:0]      target_mem [DEPTH];
  logic             jump_mem   [DEPTH];
  logic             valid_mem  [DEPTH];
  ctr_t             ctr_mem    [DEPTH];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  btb_entry_t         rd;

  assign idx = i_pc[INDEX_W+1:2];
  assign tag = i_pc[31:INDEX_W+2];

  always_comb begin
    rd        = '0;
    rd.valid  = valid_mem[idx];
    rd.tag    = MAX_TAG_W'(tag_mem[idx]);
    rd.target = target_mem[idx];
    rd.jump   = jump_mem[idx];
    rd.ctr    = ctr_mem[idx];
  end

  assign o_hit        = rd.valid && (rd.tag == MAX_TAG_W'(tag));
  assign o_pred_taken = o_hit && (rd.jump || rd.ctr[1]);
  assign o_target     = o_hit ? rd.target : 32'd0;
  assign o_pred_pc    = o_pred_taken ? o_target : i_pc + 32'd4;

  logic [INDEX_W-1:0] u_idx;
  logic [TAG_W-1:0]   u_tag;
  logic               u_hit;
  ctr_t               u_ctr_nxt;
  logic [1:0]         unused_pc_bits;

  assign u_idx          = i_pc_update[INDEX_W+1:2];
  assign u_tag          = i_pc_update[31:INDEX_W+2];
  assign u_hit          = valid_mem[u_idx] && (tag_mem[u_idx] == u_tag);
  assign unused_pc_bits = i_pc_update[1:0];

  bpred_ctr_next u_ctr_next (
    .ctr     (ctr_mem[u_idx]),
    .taken   (i_taken),
    .alloc   (!u_hit),
    .is_jump (i_is_jump),
    .nxt     (u_ctr_nxt)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_mem[i] <= 1'b0;
        ctr_mem[i]   <= STRONG_NT;
      end
    end else if (i_update_en) begin
      if (i_taken) begin
        valid_mem[u_idx] <= 1'b1;
        ctr_mem[u_idx]   <= u_ctr_nxt;
      end else if (u_hit) begin
        ctr_mem[u_idx]   <= u_ctr_nxt;
      end
    end
  end

  // Payload writes during reset are harmless: the entry stays invalid until reallocated.
  always_ff @(posedge i_clk) begin
    if (i_update_en && i_taken) begin
      tag_mem[u_idx]    <= u_tag;
      target_mem[u_idx] <= i_target_update;
      jump_mem[u_idx]   <= i_is_jump;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_br_cnt      <= '0;
      o_mispred_cnt <= '0;
    end else if (i_update_en) begin
      o_br_cnt <= o_br_cnt + 32'd1;
      if (i_mispred)
        o_mispred_cnt <= o_mispred_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_bpred_2bit.sv
// tb/tb_bpred_2bit.sv - scoreboard bench for bpred_2bit against a table-level reference model
module tb_bpred_2bit;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [31:0] i_pc = '0;
  logic        o_hit;
  logic        o_pred_taken;
  logic [31:0] o_target;
  logic [31:0] o_pred_pc;
  logic        i_update_en = 1'b0;
  logic        i_is_jump = 1'b0;
  logic [31:0] i_pc_update = '0;
  logic        i_taken = 1'b0;
  logic [31:0] i_target_update = '0;
  logic        i_mispred = 1'b0;
  logic [31:0] o_br_cnt;
  logic [31:0] o_mispred_cnt;

  bpred_2bit dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_pc            (i_pc),
    .o_hit           (o_hit),
    .o_pred_taken    (o_pred_taken),
    .o_target        (o_target),
    .o_pred_pc       (o_pred_pc),
    .i_update_en     (i_update_en),
    .i_is_jump       (i_is_jump),
    .i_pc_update     (i_pc_update),
    .i_taken         (i_taken),
    .i_target_update (i_target_update),
    .i_mispred       (i_mispred),
    .o_br_cnt        (o_br_cnt),
    .o_mispred_cnt   (o_mispred_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit          hit;
    bit          taken;
    bit [31:0]   target;
    bit [31:0]   pred_pc;
    bit [31:0]   br;
    bit [31:0]   mis;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  bit done = 0;

  // Reference table: one slot per index, counter kept as a plain 0..3 integer.
  bit        m_valid [256];
  bit [31:0] m_pc    [256];
  bit [31:0] m_tgt   [256];
  bit        m_jump  [256];
  int        m_ctr   [256];
  bit [31:0] m_br = 0;
  bit [31:0] m_mis = 0;

  bit        p_en = 0, p_jump = 0, p_taken = 0, p_mis = 0;
  bit [31:0] p_pc = 0, p_tgt = 0;

  function automatic bit same_line(input bit [31:0] a, input bit [31:0] b);
    return (a >> 2) == (b >> 2);
  endfunction

  function automatic int slot(input bit [31:0] pc);
    return int'((pc >> 2) % 256);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m_valid[i] = 0;
      m_ctr[i] = 0;
    end
    m_br = 0;
    m_mis = 0;
  endtask

  task automatic model_commit();
    int s;
    bit m;
    if (!p_en) return;
    s = slot(p_pc);
    m = m_valid[s] && same_line(m_pc[s], p_pc);
    if (p_taken) begin
      if (m) begin
        m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
      end else begin
        m_valid[s] = 1;
        m_pc[s] = p_pc;
        m_ctr[s] = p_jump ? 3 : 2;
      end
      m_tgt[s] = p_tgt;
      m_jump[s] = p_jump;
    end else if (m) begin
      m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
    end
    m_br = m_br + 1;
    if (p_mis) m_mis = m_mis + 1;
  endtask

  function automatic exp_t model_lookup(input bit [31:0] pc);
    exp_t e;
    int s = slot(pc);
    e.hit = m_valid[s] && same_line(m_pc[s], pc);
    e.taken = e.hit && (m_jump[s] || m_ctr[s] >= 2);
    e.target = e.hit ? m_tgt[s] : 32'd0;
    e.pred_pc = e.taken ? e.target : pc + 32'd4;
    e.br = m_br;
    e.mis = m_mis;
    return e;
  endfunction

  task automatic step(input bit rst_n, input bit [31:0] pc, input bit en, input bit jmp,
                      input bit [31:0] upc, input bit tk, input bit [31:0] tgt, input bit mp);
    @(posedge i_clk);
    #1;
    model_commit();
    i_reset = rst_n;
    if (!rst_n) model_reset();
    i_pc = pc;
    i_update_en = en;
    i_is_jump = jmp;
    i_pc_update = upc;
    i_taken = tk;
    i_target_update = tgt;
    i_mispred = mp;
    p_en = en && rst_n;
    p_jump = jmp;
    p_pc = upc;
    p_taken = tk;
    p_tgt = tgt;
    p_mis = mp;
    exp_q.push_back(model_lookup(pc));
  endtask

  task automatic look(input bit [31:0] pc);
    step(1, pc, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic upd(input bit [31:0] pc, input bit jmp, input bit [31:0] upc,
                     input bit tk, input bit [31:0] tgt, input bit mp);
    step(1, pc, 1, jmp, upc, tk, tgt, mp);
  endtask

  task automatic check(input string name, input bit [31:0] act, input bit [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("hit", {31'd0, o_hit}, {31'd0, e.hit});
        check("pred_taken", {31'd0, o_pred_taken}, {31'd0, e.taken});
        check("target", o_target, e.target);
        check("pred_pc", o_pred_pc, e.pred_pc);
        check("br_cnt", o_br_cnt, e.br);
        check("mispred_cnt", o_mispred_cnt, e.mis);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    if (!done) begin
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
    end
  end

  bit [31:0] pool [8];

  initial begin : driver
    model_reset();
    step(0, 32'h100, 0, 0, 0, 0, 0, 0);
    step(1, 32'h100, 0, 0, 0, 0, 0, 0);

    // Allocate a branch then saturate it.
    upd(32'h40, 0, 32'h40, 1, 32'h80, 0);
    look(32'h40);
    for (int i = 0; i < 3; i++) upd(32'h40, 0, 32'h40, 1, 32'h80, 0);
    look(32'h40);
    // Hysteresis: two not-taken outcomes needed to flip.
    upd(32'h40, 0, 32'h40, 0, 32'h0, 1);
    look(32'h40);
    upd(32'h40, 0, 32'h40, 0, 32'h0, 1);
    look(32'h40);
    // Alias at the same index replaces the branch.
    upd(32'h40, 1, 32'h440, 1, 32'h900, 0);
    look(32'h40);
    look(32'h440);
    // Back-to-back updates at the same index while looking it up.
    upd(32'h440, 0, 32'h40, 1, 32'h1234, 0);
    upd(32'h40, 0, 32'h40, 0, 32'h0, 0);
    upd(32'h40, 0, 32'h40, 0, 32'h0, 1);
    look(32'h40);
    // Reset mid-cycle with an update pending, then hold reset with an update.
    step(0, 32'h40, 1, 0, 32'h40, 1, 32'h80, 1);
    step(0, 32'h40, 1, 0, 32'h40, 1, 32'h80, 1);
    step(1, 32'h40, 0, 0, 0, 0, 0, 0);

    pool[0] = 32'h40;       pool[1] = 32'h440;
    pool[2] = 32'h8000_0040; pool[3] = 32'h1000;
    pool[4] = 32'h1004;     pool[5] = 32'hffff_fffc;
    pool[6] = 32'h2000_03fc; pool[7] = 32'h3c;
    for (int n = 0; n < 600; n++) begin
      bit jmp;
      bit tk;
      jmp = ($urandom_range(0, 3) == 0);
      tk = jmp ? 1'b1 : 1'($urandom_range(0, 1));
      if (n == 300)
        step(0, pool[$urandom_range(0, 7)], 1, jmp, pool[$urandom_range(0, 7)], tk, $urandom, 1);
      else
        step(1, pool[$urandom_range(0, 7)], 1'($urandom_range(0, 3) != 0), jmp,
             pool[$urandom_range(0, 7)], tk, $urandom & 32'hffff_fffc, 1'($urandom_range(0, 1)));
    end

    look(32'h40);
    @(negedge i_clk);
    @(negedge i_clk);
    check("queue_drained", exp_q.size(), 0);
    done = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bpred_2bit.md
# bpred_2bit

Dynamic branch predictor for the fetch stage of the 5-stage pipelined core. It replaces the static always-taken BTB policy with a direct-mapped BTB whose entries each carry a 2-bit saturating direction counter. Lookup is combinational on the fetch PC and produces the predicted next PC. Updates come from the execute stage once the branch outcome is resolved. Two performance counters track resolved control-flow instructions and mispredictions.

## Interface
Parameters:
- `INDEX_W`, default 8: index bits; the table holds 2^INDEX_W entries.
- `TAG_W`, default 30-INDEX_W: tag bits, taken from pc[31:INDEX_W+2].

Ports:
- `i_clk`  in  1  system clock. All state updates on its rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_pc`  in  32  fetch-stage PC.
- `o_hit`  out  1  a valid entry matches the tag of `i_pc`.
- `o_pred_taken`  out  1  predicted taken.
- `o_target`  out  32  stored target; 0 when `o_hit`=0.
- `o_pred_pc`  out  32  `o_pred_taken` ? `o_target` : `i_pc`+4.
- `i_update_en`  in  1  a valid branch or jump is resolving in execute. Must be 0 for bubbles and flushed slots.
- `i_is_jump`  in  1  the resolving instruction is JAL or JALR.
- `i_pc_update`  in  32  PC of the resolving instruction.
- `i_taken`  in  1  actual outcome. Always 1 for jumps.
- `i_target_update`  in  32  actual target, i.e. the ALU result.
- `i_mispred`  in  1  the execute stage detected a misprediction.
- `o_br_cnt`  out  32  count of resolved control-flow instructions.
- `o_mispred_cnt`  out  32  count of mispredictions.

## Operation
Each entry holds: valid, tag, target[31:0], jump bit, ctr[1:0].

Lookup (combinational):
- idx = pc[INDEX_W+1:2].
- `o_hit` = valid[idx] & (tag[idx] == pc[31:INDEX_W+2]).
- `o_pred_taken` = `o_hit` & (jump[idx] | ctr[idx][1]).

Update (rising edge, only when `i_update_en`=1). Let m = entry at idx(`i_pc_update`) is valid and its tag matches.
- `i_taken`=1, m=1: overwrite target and jump bit; ctr = sat_inc(ctr).
- `i_taken`=1, m=0: allocate the entry (replaces any resident entry). Set valid=1, write tag, target and jump bit. ctr = 2'b11 for a jump, 2'b10 (weakly taken) for a branch.
- `i_taken`=0, m=1: ctr = sat_dec(ctr). Target is unchanged.
- `i_taken`=0, m=0: no table change. Not-taken branches are never allocated.

Counter saturation:
- 2'b11 stays at 2'b11 on increment.
- 2'b00 stays at 2'b00 on decrement.

Performance counters:
- `o_br_cnt` += 1 when `i_update_en`.
- `o_mispred_cnt` += 1 when `i_update_en` & `i_mispred`.
- Both wrap modulo 2^32.

## Timing
- Lookup latency is 0 cycles, purely combinational from `i_pc`.
- An update becomes visible to lookup in the cycle after the capturing edge.
- Simultaneous lookup and update at the same index: lookup returns the pre-update contents. There is no bypass.
- Consecutive updates to the same index in back-to-back cycles each apply to the result of the previous one.
- Reset, asserted at any time including mid-update:
  - all valid bits clear immediately; ctr clears to 2'b00.
  - `o_br_cnt` and `o_mispred_cnt` clear to 0.
  - `o_hit`, `o_pred_taken` and `o_target` go to 0; `o_pred_pc` = `i_pc`+4.
  - Tag, target and jump storage need not reset.
- While reset is low, updates are ignored.
- Fetch stall does not affect the block: outputs keep following `i_pc`.

## Structure
- Package `bpred_pkg` holds:
  - enum `ctr_t`: STRONG_NT=2'b00, WEAK_NT=2'b01, WEAK_T=2'b10, STRONG_T=2'b11.
  - struct `btb_entry_t` with fields valid, tag, target, jump, ctr.
  - functions `sat_inc` and `sat_dec`.
- Sub-module `bpred_ctr_next` is the combinational next-counter function. It takes (ctr, taken, alloc, is_jump) and returns the next ctr.
- Table storage: tag, target and jump in plain registers. Valid and ctr sit in an asynchronously reset register array.

## Test plan
- **Reset:** release reset, `i_pc`=0x0000_0100 -> `o_hit`=0, `o_pred_pc`=0x0000_0104, both counters 0.
- **Branch allocation and saturation:** taken branch update at pc 0x40, target 0x80 -> next cycle, lookup 0x40 gives hit=1, pred_taken=1, pred_pc=0x80, ctr=WEAK_T. Three more taken updates -> ctr stays STRONG_T.
- **Hysteresis:** from STRONG_T, one not-taken update -> WEAK_T, still predicts taken. A second not-taken update -> WEAK_NT, pred_pc=0x44, hit still 1.
- **Alias replacement:** with INDEX_W=8, a taken jump at 0x440 (same index as 0x40) -> lookup 0x40 misses; lookup 0x440 hits with ctr=STRONG_T.
- **Same-cycle conflict:** update at index 0x10 while `i_pc` maps to index 0x10 -> outputs show old contents that cycle and new contents the next cycle.
- **Counters and reset:** 5 updates, 2 with `i_mispred`=1 -> br_cnt=5, mispred_cnt=2. Assert reset mid-cycle -> both 0 and all lookups miss immediately.
